// File: rtl/btn_cmd_conditioner.sv
// btn_cmd_conditioner
//   Synchronises and debounces NUM_BTN push buttons on a divided sample tick,
//   turns debounced rising edges into one-cycle press pulses, encodes each
//   press (lowest index wins) into a command and queues it in a small FIFO
//   drained through a valid/ready handshake.
//
//   Optional build macro: BTN_AUTOREPEAT_EN
//     When defined, a held button re-issues a press REPEAT_DELAY ticks after
//     its rising edge and then every REPEAT_RATE ticks.
//
// Ports
//   ClkPort      in   system clock
//   rst          in   asynchronous active-high reset
//   btn_raw      in   [NUM_BTN] raw asynchronous button levels
//   tick         out  one-cycle sample strobe (every 2^DIV_BITS clocks)
//   btn_level    out  [NUM_BTN] debounced levels
//   btn_press    out  [NUM_BTN] one-cycle pulse per debounced 0->1 edge
//   cmd_data     out  [CMD_W] FIFO head (button index), 0 while empty
//   cmd_valid    out  FIFO non-empty
//   cmd_ready    in   consumer accepts the head this cycle
//   cmd_overflow out  sticky: a command was dropped on a full FIFO
module btn_cmd_conditioner #(
  parameter int unsigned NUM_BTN      = 5,
  parameter int unsigned CMD_W        = 3,
  parameter int unsigned DIV_BITS     = 20,
  parameter int unsigned DEB_COUNT    = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_DELAY = 32,
  parameter int unsigned REPEAT_RATE  = 8
) (
  input  logic               ClkPort,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic               tick,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [CMD_W-1:0]   cmd_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_overflow
);

  localparam int unsigned DEB_W = (DEB_COUNT > 1) ? $clog2(DEB_COUNT) : 1;
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX   = DEB_W'(DEB_COUNT - 1);
  localparam logic [AW:0]      FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  // Elaboration-time parameter sanity checks
  if ((2 ** CMD_W) < NUM_BTN) begin : g_chk_cmd_w
    $error("CMD_W too narrow for NUM_BTN");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (DEB_COUNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_chk_counts
    $error("DEB_COUNT, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  logic [NUM_BTN-1:0]             r_sync1;
  logic [NUM_BTN-1:0]             r_sync2;
  logic [DIV_BITS-1:0]            r_div;
  logic                           w_tick;
  logic [NUM_BTN-1:0][DEB_W-1:0]  r_deb_cnt;
  logic [NUM_BTN-1:0]             r_level;
  logic [NUM_BTN-1:0]             r_level_q;
  logic [NUM_BTN-1:0]             r_press;
  logic [NUM_BTN-1:0]             w_rep_fire;
  logic                           w_push;
  logic [CMD_W-1:0]               w_enc;
  logic [CMD_W-1:0]               r_mem [FIFO_DEPTH];
  logic [AW-1:0]                  r_wptr;
  logic [AW-1:0]                  r_rptr;
  logic [AW:0]                    r_count;
  logic                           w_valid;
  logic                           w_full;
  logic                           w_pop;
  logic                           w_push_ok;
  logic                           w_drop;
  logic                           r_overflow;

  // Two-flop synchroniser
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample divider; tick on the all-ones count
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) r_div <= '0;
    else     r_div <= r_div + DIV_BITS'(1);
  end

  assign w_tick = &r_div;

  // Debounce: DEB_COUNT consecutive differing samples flip the level
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      r_deb_cnt <= '0;
      r_level   <= '0;
    end else if (w_tick) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_MAX) begin
          r_level[i]   <= ~r_level[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_DLY_END  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_END = REP_W'(REPEAT_RATE - 1);

  logic [NUM_BTN-1:0][REP_W-1:0] r_rep_cnt;
  logic [NUM_BTN-1:0]            r_rep_run;  // 0: initial delay, 1: repeating

  always_comb begin
    w_rep_fire = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      w_rep_fire[i] = w_tick & r_level[i] &
                      (r_rep_run[i] ? (r_rep_cnt[i] == REP_RATE_END)
                                    : (r_rep_cnt[i] == REP_DLY_END));
    end
  end

  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      r_rep_cnt <= '0;
      r_rep_run <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (!r_level[i]) begin
          r_rep_cnt[i] <= '0;
          r_rep_run[i] <= 1'b0;
        end else if (w_rep_fire[i]) begin
          r_rep_cnt[i] <= '0;
          r_rep_run[i] <= 1'b1;
        end else if (w_tick) begin
          r_rep_cnt[i] <= r_rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end
`else
  assign w_rep_fire = '0;
`endif

  // Press pulse lands the cycle after the debounced level rises
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      r_level_q <= '0;
      r_press   <= '0;
    end else begin
      r_level_q <= r_level;
      r_press   <= (r_level & ~r_level_q) | w_rep_fire;
    end
  end

  // Lowest set press index wins; the rest are dropped silently
  always_comb begin
    w_push = 1'b0;
    w_enc  = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (r_press[i] && !w_push) begin
        w_push = 1'b1;
        w_enc  = CMD_W'(i);
      end
    end
  end

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == FIFO_FULL);
  assign w_pop     = w_valid & cmd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge ClkPort) begin
    if (w_push_ok) r_mem[r_wptr] <= w_enc;
  end

  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) r_overflow <= 1'b0;
    else     r_overflow <= r_overflow | w_drop;
  end

  assign tick         = w_tick;
  assign btn_level    = r_level;
  assign btn_press    = r_press;
  assign cmd_valid    = w_valid;
  assign cmd_data     = w_valid ? r_mem[r_rptr] : '0;
  assign cmd_overflow = r_overflow;

endmodule

// File: tb/tb_btn_cmd_conditioner.sv
module tb_btn_cmd_conditioner;

  logic       ClkPort = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic       tick;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [2:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  int press_cnt [5];
  int exp_q [$];

  typedef struct {
    logic [4:0] raw;
    int         cmd;
  } vec_t;

  vec_t vecs [6];

  always #5 ClkPort = ~ClkPort;

  btn_cmd_conditioner #(
    .NUM_BTN(5), .CMD_W(3), .DIV_BITS(2), .DEB_COUNT(3), .FIFO_DEPTH(2),
    .REPEAT_DELAY(32), .REPEAT_RATE(8)
  ) dut (
    .ClkPort(ClkPort), .rst(rst), .btn_raw(btn_raw), .tick(tick),
    .btn_level(btn_level), .btn_press(btn_press), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_overflow(cmd_overflow)
  );

  task automatic check(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)", name, actual, required, cyc);
    end
  endtask

  // One clock; a pending handshake is scored against the expected queue first
  task automatic step();
    int e;
    if (cmd_valid && cmd_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got cmd %0d required none", int'(cmd_data));
      end else begin
        e = exp_q.pop_front();
        check("sb_cmd", int'(cmd_data), e);
      end
    end
    for (int i = 0; i < 5; i++) press_cnt[i] += int'(btn_press[i]);
    @(posedge ClkPort);
    #1;
    cyc++;
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 5; i++) press_cnt[i] = 0;
  endtask

  task automatic align();
    while (cyc % 4 != 0) step();
  endtask

  task automatic press_release(input logic [4:0] pat);
    align();
    btn_raw = pat;
    repeat (16) step();
    btn_raw = '0;
    repeat (16) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int pops0;
    int sum;

    vecs[0] = '{raw: 5'b00100, cmd: 2};
    vecs[1] = '{raw: 5'b01010, cmd: 1};
    vecs[2] = '{raw: 5'b10000, cmd: 4};
    vecs[3] = '{raw: 5'b00001, cmd: 0};
    vecs[4] = '{raw: 5'b11000, cmd: 3};
    vecs[5] = '{raw: 5'b11111, cmd: 0};

    rst = 1'b1;
    btn_raw = '0;
    cmd_ready = 1'b0;
    clear_cnt();
    repeat (3) step();
    check("rst_tick", int'(tick), 0);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_data", int'(cmd_data), 0);
    check("rst_level", int'(btn_level), 0);
    check("rst_press", int'(btn_press), 0);
    check("rst_ovf", int'(cmd_overflow), 0);
    rst = 1'b0;
    cyc = 0;

    // Divider phase: tick during the cycle where the counter reads 3
    for (int i = 0; i < 8; i++) begin
      step();
      check("tick_phase", int'(tick), int'(cyc % 4 == 3));
    end

    // Exact latency of a clean press on btn 2
    clear_cnt();
    btn_raw[2] = 1'b1;
    exp_q.push_back(2);
    repeat (11) step();
    check("lat_level_early", int'(btn_level), 0);
    step();
    check("lat_level", int'(btn_level), 5'b00100);
    check("lat_press_early", int'(btn_press), 0);
    step();
    check("lat_press", int'(btn_press), 5'b00100);
    check("lat_valid_early", int'(cmd_valid), 0);
    step();
    check("lat_press_end", int'(btn_press), 0);
    check("lat_valid", int'(cmd_valid), 1);
    check("lat_data", int'(cmd_data), 2);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("lat_valid_pop", int'(cmd_valid), 0);
    btn_raw = '0;
    repeat (16) step();
    check("lat_release_level", int'(btn_level), 0);
    check("lat_press_count", press_cnt[2], 1);

    // Bouncing input: alternating samples never settle
    align();
    clear_cnt();
    pops0 = pops;
    for (int n = 0; n < 12; n++) begin
      btn_raw[0] = ~btn_raw[0];
      repeat (4) step();
      check("bounce_level", int'(btn_level[0]), 0);
    end
    repeat (16) step();
    check("bounce_press", press_cnt[0], 0);
    check("bounce_valid", int'(cmd_valid), 0);
    check("bounce_pops", pops - pops0, 0);

    // Table: pattern in, one command out (lowest index), no release pulse
    for (int v = 0; v < 6; v++) begin
      clear_cnt();
      align();
      btn_raw = vecs[v].raw;
      exp_q.push_back(vecs[v].cmd);
      cmd_ready = 1'b1;
      repeat (20) step();
      check("tbl_level", int'(btn_level), int'(vecs[v].raw));
      for (int i = 0; i < 5; i++) check("tbl_press", press_cnt[i], int'(vecs[v].raw[i]));
      btn_raw = '0;
      repeat (16) step();
      check("tbl_release", int'(btn_level), 0);
      sum = 0;
      for (int i = 0; i < 5; i++) sum += press_cnt[i];
      check("tbl_no_release_pulse", sum, $countones(vecs[v].raw));
      check("tbl_sb_empty", exp_q.size(), 0);
      check("tbl_ovf", int'(cmd_overflow), 0);
      cmd_ready = 1'b0;
    end

    // Full FIFO (0,1) with a pop coinciding with a btn-2 push
    clear_cnt();
    exp_q.push_back(0);
    press_release(5'b00001);
    exp_q.push_back(1);
    press_release(5'b00010);
    check("full_valid", int'(cmd_valid), 1);
    check("full_head", int'(cmd_data), 0);
    align();
    btn_raw = 5'b00100;
    exp_q.push_back(2);
    repeat (13) step();
    check("full_press", int'(btn_press), 5'b00100);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("full_after_head", int'(cmd_data), 1);
    check("full_ovf", int'(cmd_overflow), 0);
    btn_raw = '0;
    cmd_ready = 1'b1;
    repeat (20) step();
    cmd_ready = 1'b0;
    check("full_sb_empty", exp_q.size(), 0);
    check("full_drained", int'(cmd_valid), 0);
    check("full_ovf_end", int'(cmd_overflow), 0);

    // Overflow: three btn-4 presses into a depth-2 FIFO with no consumer
    exp_q.push_back(4);
    press_release(5'b10000);
    exp_q.push_back(4);
    press_release(5'b10000);
    check("ovf_not_yet", int'(cmd_overflow), 0);
    press_release(5'b10000);
    check("ovf_set", int'(cmd_overflow), 1);
    check("ovf_valid", int'(cmd_valid), 1);
    check("ovf_head", int'(cmd_data), 4);
    pops0 = pops;
    cmd_ready = 1'b1;
    repeat (6) step();
    cmd_ready = 1'b0;
    check("ovf_pops", pops - pops0, 2);
    check("ovf_valid_end", int'(cmd_valid), 0);
    check("ovf_sticky", int'(cmd_overflow), 1);
    check("ovf_sb_empty", exp_q.size(), 0);

    // Reset mid-debounce with one stale entry in the FIFO
    press_release(5'b00001);
    check("mid_valid_pre", int'(cmd_valid), 1);
    align();
    btn_raw = 5'b01000;
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("mid_rst_tick", int'(tick), 0);
    check("mid_rst_valid", int'(cmd_valid), 0);
    check("mid_rst_data", int'(cmd_data), 0);
    check("mid_rst_level", int'(btn_level), 0);
    check("mid_rst_press", int'(btn_press), 0);
    check("mid_rst_ovf", int'(cmd_overflow), 0);
    repeat (2) step();
    rst = 1'b0;
    cyc = 0;
    clear_cnt();
    repeat (11) step();
    check("mid_level_early", int'(btn_level[3]), 0);
    step();
    check("mid_level", int'(btn_level[3]), 1);
    step();
    check("mid_press", int'(btn_press), 5'b01000);
    check("mid_valid_early", int'(cmd_valid), 0);
    step();
    check("mid_valid", int'(cmd_valid), 1);
    check("mid_data", int'(cmd_data), 3);
    exp_q.push_back(3);
    cmd_ready = 1'b1;
    step();
    step();
    cmd_ready = 1'b0;
    check("mid_valid_end", int'(cmd_valid), 0);
    check("mid_sb_empty", exp_q.size(), 0);
    check("mid_press_count", press_cnt[3], 1);
    btn_raw = '0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_cmd_conditioner.md
Name: btn_cmd_conditioner

Overview:
- Parametrised, multi-channel successor to the ad-hoc clock-divider and raw-button hookup in the game top level.
- Synchronises and debounces NUM_BTN push-button inputs on a divided sample tick.
- Generates one-cycle press pulses and encodes presses into move commands.
- Buffers commands in a small FIFO with a valid/ready handshake, so a slow game FSM loses no moves.

Parameters:
- NUM_BTN, 5: number of button channels (index 0..NUM_BTN-1).
- CMD_W, 3: command index width; must satisfy 2^CMD_W >= NUM_BTN.
- DIV_BITS, 20: sample-tick divider width; tick period 2^DIV_BITS clocks.
- DEB_COUNT, 4: consecutive differing samples required to flip a debounced level (>=1).
- FIFO_DEPTH, 4: command FIFO entries (power of two, >=2).
- REPEAT_DELAY, 32: ticks before first auto-repeat (used only with the optional feature).
- REPEAT_RATE, 8: ticks between subsequent repeats (used only with the optional feature).

Ports:
- ClkPort, input, 1: system clock.
- rst, input, 1: reset; asynchronous, active-high.
- btn_raw, input, NUM_BTN: asynchronous raw button levels.
- tick, output, 1: one-cycle sample strobe.
- btn_level, output, NUM_BTN: debounced levels.
- btn_press, output, NUM_BTN: one-cycle pulse on each debounced 0->1 edge.
- cmd_data, output, CMD_W: FIFO head (button index); valid only while cmd_valid=1.
- cmd_valid, output, 1: FIFO non-empty.
- cmd_ready, input, 1: consumer accepts the head this cycle.
- cmd_overflow, output, 1: sticky; a command was dropped.

Behaviour:
- Reset (async, rst=1):
  - Clears the synchronisers, divider, debounce counters, btn_level, btn_press, FIFO pointers, count and cmd_overflow.
  - Outputs during and after reset: tick=0, cmd_valid=0, cmd_data=0.
  - Reset mid-debounce or with a non-empty FIFO discards all state; no partial command survives.
- Synchroniser: 2-flop per channel; sync = second stage.
- Divider: DIV_BITS-bit free-running counter from 0. tick=1 for the one cycle where counter == 2^DIV_BITS-1, then wraps to 0.
- Debounce, per channel, evaluated only on tick:
  - sync == btn_level: counter cleared.
  - Otherwise counter increments.
  - When the counter reaches DEB_COUNT-1 on a differing sample, btn_level toggles and the counter clears.
  - Latency from a clean stable edge: 2 sync cycles plus DEB_COUNT ticks.
- btn_press[i] = btn_level[i] rising, registered. High exactly one cycle, the cycle after btn_level rises. Releases produce no pulse.
- Encode:
  - Any btn_press bit set -> push request with data = lowest set index.
  - Other simultaneous presses are discarded silently; this is not an overflow.
- FIFO:
  - push accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs the same cycle.
  - pop = cmd_valid & cmd_ready.
  - Push+pop same cycle: count unchanged, order preserved.
  - Empty FIFO: cmd_valid rises the cycle after the push (first-word latency 1).
  - cmd_data is stable while cmd_valid=1 and cmd_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_ready while empty is a no-op.
- Overflow: push while full without a pop drops the command. cmd_overflow sets the next cycle and holds until rst.

Optional Feature:
- BTN_AUTOREPEAT_EN defined:
  - Per-channel repeat counter in ticks, cleared when btn_level is 0.
  - While btn_level=1, an extra btn_press pulse is generated REPEAT_DELAY ticks after the rising edge, then every REPEAT_RATE ticks.
  - Repeat pulses are encoded and pushed exactly like real presses.
- Undefined: exactly one btn_press per debounced 0->1 edge; no repeat counters synthesised.

Test Plan (DIV_BITS=2, DEB_COUNT=3, FIFO_DEPTH=2, NUM_BTN=5):
- Raw[2] 0->1, held -> btn_level[2]=1 after 2 sync cycles + 3 ticks; btn_press[2] one cycle; next cycle cmd_valid=1, cmd_data=2; cmd_ready=1 one cycle -> cmd_valid=0.
- Raw[0] toggled every 4 clocks for 48 clocks (alternating samples) -> btn_level[0] stays 0, no press, cmd_valid stays 0.
- Raw[1] and raw[3] rise the same cycle -> single command cmd_data=1; cmd_overflow=0.
- cmd_ready=0, three separate debounced presses of btn 4 -> FIFO holds 4,4; cmd_overflow=1. Then cmd_ready=1 -> exactly 2 pops, cmd_overflow stays 1.
- FIFO full (0,1), cmd_ready=1 in the same cycle as a btn-2 press -> 0 popped, 2 accepted; sequence read out 1,2; cmd_overflow=0.
- rst pulsed while a btn-3 debounce is at count 1 with FIFO holding one entry -> all outputs 0. Raw[3] still high after release -> press after the full latency, single command 3.
